wam_autoplayer: RTL

//  Parametrised, synthesisable autoplayer/self-checker for the whack-a-mole game core.

---
 rtl/wam_autoplayer_pkg.sv | 17 +
 rtl/wam_autoplayer_down_counter.sv | 26 ++
 rtl/wam_autoplayer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/wam_autoplayer_pkg.sv
// Shared types and sizing helpers for the whack-a-mole autoplayer.
package wam_autoplayer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_PRESS   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_CHECK   = 3'd4
    } state_t;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/wam_autoplayer_down_counter.sv
// Loadable down counter that stops at zero and flags it.
module wam_autoplayer_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // Load wins over decrement; the count parks at zero until reloaded.
    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/wam_autoplayer.sv
// Autoplayer / self-checker: presses the active mole after a delay and
// cross-checks the game core's score against its own hit count.
module wam_autoplayer
    import wam_autoplayer_pkg::*;
#(
    parameter int NUM_MOLES    = 4,
    parameter int DELAY_W      = 8,
    parameter int PRESS_CYCLES = 4,
    parameter int SCORE_W      = 8,
    parameter int SCORE_LAT    = 2,
    parameter int TIMEOUT      = 255,
    parameter int MISS_EVERY   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [DELAY_W-1:0]   cfg_delay,
    input  logic [NUM_MOLES-1:0] mole_in,
    input  logic [SCORE_W-1:0]   score_in,
    output logic [NUM_MOLES-1:0] btn_out,
    output logic                 busy,
    output logic [SCORE_W-1:0]   hits,
    output logic [SCORE_W-1:0]   misses,
    output logic                 err_score,
    output logic                 err_multi,
    output logic                 err_stuck
);

    localparam int PW      = cnt_w(PRESS_CYCLES - 1);
    localparam int LW      = cnt_w(SCORE_LAT);
    localparam int TW      = cnt_w(TIMEOUT - 1);
    localparam int ME_LAST = (MISS_EVERY > 0) ? MISS_EVERY - 1 : 0;
    localparam int MW      = cnt_w(ME_LAST);

    state_t                 state, state_nxt;
    logic [NUM_MOLES-1:0]   cur, btn_nxt;
    logic [MW-1:0]          phase;
    logic                   skip_cur;
    logic                   dly_zero, press_zero, lat_zero, to_zero;
    logic                   detect, start_press, do_skip, hit_inc, miss_inc;
    logic                   load_to, load_lat, stuck, check_now;

    wire mole_onehot = $onehot(mole_in);
    wire mole_multi  = ($countones(mole_in) > 1);
    wire changed     = (mole_in != cur);

    wam_autoplayer_down_counter #(.W(DELAY_W)) u_dly (
        .clk(clk), .rst_n(rst_n), .load(detect), .load_val(cfg_delay), .zero(dly_zero));
    wam_autoplayer_down_counter #(.W(PW)) u_press (
        .clk(clk), .rst_n(rst_n), .load(start_press), .load_val(PW'(PRESS_CYCLES - 1)),
        .zero(press_zero));
    wam_autoplayer_down_counter #(.W(LW)) u_lat (
        .clk(clk), .rst_n(rst_n), .load(load_lat), .load_val(LW'(SCORE_LAT)), .zero(lat_zero));
    wam_autoplayer_down_counter #(.W(TW)) u_to (
        .clk(clk), .rst_n(rst_n), .load(load_to), .load_val(TW'(TIMEOUT - 1)), .zero(to_zero));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; dropping ena aborts from anywhere.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (ena && mole_onehot) state_nxt = ST_WAIT;
            ST_WAIT:    if (changed)            state_nxt = ST_IDLE;
                        else if (dly_zero)      state_nxt = skip_cur ? ST_RELEASE : ST_PRESS;
            ST_PRESS:   if (press_zero)         state_nxt = ST_RELEASE;
            ST_RELEASE: if (changed)            state_nxt = ST_CHECK;
                        else if (to_zero)       state_nxt = ST_IDLE;
            ST_CHECK:   if (lat_zero)           state_nxt = ST_IDLE;
            default:                            state_nxt = ST_IDLE;
        endcase
        if (!ena) state_nxt = ST_IDLE;
    end

    // Per-state strobes and next button value; all gated by ena so an abort counts nothing.
    always_comb begin
        detect      = (state == ST_IDLE) && ena && mole_onehot;
        start_press = (state == ST_WAIT) && ena && !changed && dly_zero && !skip_cur;
        do_skip     = (state == ST_WAIT) && ena && !changed && dly_zero && skip_cur;
        miss_inc    = ((state == ST_WAIT) && ena && changed) || do_skip;
        hit_inc     = (state == ST_PRESS) && ena && press_zero;
        load_to     = hit_inc || do_skip;
        load_lat    = (state == ST_RELEASE) && ena && changed;
        stuck       = (state == ST_RELEASE) && ena && !changed && to_zero;
        check_now   = (state == ST_CHECK) && ena && lat_zero;
        btn_nxt     = '0;
        if (start_press || ((state == ST_PRESS) && ena && !press_zero))
            btn_nxt = cur;
    end

    // Registered outputs, mole latch, skip phase, saturating counters and sticky flags.
    // The skip phase is a modulo-MISS_EVERY counter, i.e. the mole sequence number mod N.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_out   <= '0;
            busy      <= 1'b0;
            cur       <= '0;
            phase     <= '0;
            skip_cur  <= 1'b0;
            hits      <= '0;
            misses    <= '0;
            err_score <= 1'b0;
            err_multi <= 1'b0;
            err_stuck <= 1'b0;
        end else begin
            btn_out <= btn_nxt;
            busy    <= (state_nxt != ST_IDLE);
            if (detect) begin
                cur      <= mole_in;
                skip_cur <= (MISS_EVERY != 0) && (phase == MW'(ME_LAST));
                phase    <= (phase == MW'(ME_LAST)) ? '0 : phase + 1'b1;
            end
            if (hit_inc && (hits != '1))    hits   <= hits + 1'b1;
            if (miss_inc && (misses != '1)) misses <= misses + 1'b1;
            if (ena && mole_multi)          err_multi <= 1'b1;
            if (stuck)                      err_stuck <= 1'b1;
            if (check_now && (score_in != hits)) err_score <= 1'b1;
        end
    end

endmodule
